// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants for the pipeline stall controller: hold-vector width and values,
// FSM encoding and the reset-active level.
package pipe_stall_ctrl_pkg;

    localparam int STALL_W = 6;
    typedef logic [STALL_W-1:0] stall_t;

    // Bit order: PC, IF/ID, ID/EX, EX/MEM, MEM/WB, WB
    localparam stall_t STALL_NONE = 6'b000000;
    localparam stall_t STALL_ID   = 6'b000111;
    localparam stall_t STALL_EX   = 6'b001111;

    localparam logic RST_ACTIVE = 1'b0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard/flush request inputs and stall/flush responses between the pipeline and
// its stall controller.
interface pipe_stall_ctrl_if #(
    parameter int MC_CNT_W = 6
);
    import pipe_stall_ctrl_pkg::*;

    logic                id_stall_req;
    logic                ex_mc_start;
    logic [MC_CNT_W-1:0] ex_mc_cycles;
    logic                flush_req;
    stall_t              stall;
    logic                flush;
    logic                ex_mc_busy;
    logic                ex_mc_done;

    modport master (
        output id_stall_req, ex_mc_start, ex_mc_cycles, flush_req,
        input  stall, flush, ex_mc_busy, ex_mc_done
    );

    modport slave (
        input  id_stall_req, ex_mc_start, ex_mc_cycles, flush_req,
        output stall, flush, ex_mc_busy, ex_mc_done
    );

endinterface

// File: rtl/pipe_stall_ctrl_mc_timer.sv
// Down-counter for multi-cycle EX operations: clear, load, decrement, and an is-one flag
// that marks the last stalled cycle.
module mc_timer
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         is_one
);

    logic [W-1:0] cnt_reg;

    // Clear beats load beats decrement; the zero guard keeps the count from wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (dec && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - W'(1);
        end
    end

    assign is_one = (cnt_reg == W'(1));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: flush > multi-cycle EX hold > ID hazard hold.
// Outputs are combinational so a hold applies in the same cycle it is requested.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MC_CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    pipe_stall_ctrl_if.slave bus
);

    state_t state_reg;
    logic   accept;
    logic   multi;
    logic   is_one;

    // A zero-length request is treated as no request at all.
    assign accept = (state_reg == ST_IDLE) && !bus.flush_req && bus.ex_mc_start
                    && (bus.ex_mc_cycles != '0);
    assign multi  = accept && (bus.ex_mc_cycles >= MC_CNT_W'(2));

    mc_timer #(
        .W        (MC_CNT_W)
    ) u_mc_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (bus.flush_req),
        .load     (multi),
        .load_val (bus.ex_mc_cycles - MC_CNT_W'(1)),
        .dec      ((state_reg == ST_BUSY) && !bus.flush_req),
        .is_one   (is_one)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            state_reg <= ST_IDLE;
        end else if (bus.flush_req) begin
            state_reg <= ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: if (multi)  state_reg <= ST_BUSY;
                ST_BUSY: if (is_one) state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.stall      = STALL_NONE;
        bus.flush      = 1'b0;
        bus.ex_mc_busy = 1'b0;
        bus.ex_mc_done = 1'b0;
        if (rst != RST_ACTIVE) begin
            bus.ex_mc_busy = (state_reg == ST_BUSY);
            if (bus.flush_req) begin
                bus.flush = 1'b1;
            end else if (state_reg == ST_BUSY) begin
                bus.stall      = STALL_EX;
                bus.ex_mc_done = is_one;
            end else if (accept) begin
                // Single-cycle op completes here without ever entering BUSY.
                bus.stall      = STALL_EX;
                bus.ex_mc_done = (bus.ex_mc_cycles == MC_CNT_W'(1));
            end else if (bus.id_stall_req) begin
                bus.stall = STALL_ID;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: stimulus pushes expected outputs into a queue,
// a negedge monitor pops and compares each one.
module tb_pipe_stall_ctrl;

    localparam int MC_CNT_W = 6;

    typedef struct {
        string      name;
        logic [5:0] stall;
        logic       flush;
        logic       busy;
        logic       done;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb[$];
    exp_t mon_e;
    int   n_checks;
    int   n_pass;

    pipe_stall_ctrl_if #(.MC_CNT_W(MC_CNT_W)) bus ();

    pipe_stall_ctrl #(.MC_CNT_W(MC_CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One cycle: drive inputs just after the rising edge, queue what the next negedge must show.
    task automatic cyc(input string name, input logic r, input logic id, input logic st,
                       input int n, input logic fl, input logic [5:0] e_stall,
                       input logic e_flush, input logic e_busy, input logic e_done);
        exp_t e;
        @(posedge clk);
        #1;
        rst              = r;
        bus.id_stall_req = id;
        bus.ex_mc_start  = st;
        bus.ex_mc_cycles = MC_CNT_W'(n);
        bus.flush_req    = fl;
        e.name  = name;
        e.stall = e_stall;
        e.flush = e_flush;
        e.busy  = e_busy;
        e.done  = e_done;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            n_checks++;
            if (bus.stall === mon_e.stall && bus.flush === mon_e.flush &&
                bus.ex_mc_busy === mon_e.busy && bus.ex_mc_done === mon_e.done) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got stall=%b flush=%b busy=%b done=%b, want stall=%b flush=%b busy=%b done=%b",
                         mon_e.name, bus.stall, bus.flush, bus.ex_mc_busy, bus.ex_mc_done,
                         mon_e.stall, mon_e.flush, mon_e.busy, mon_e.done);
            end
            $display("t=%0t %s stall=%b flush=%b busy=%b done=%b", $time, mon_e.name,
                     bus.stall, bus.flush, bus.ex_mc_busy, bus.ex_mc_done);
        end
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst              = 1'b0;
        bus.id_stall_req = 1'b1;
        bus.ex_mc_start  = 1'b1;
        bus.ex_mc_cycles = '1;
        bus.flush_req    = 1'b1;

        // Reset held with every input high, then release to idle
        cyc("rst_hold0", 0, 1, 1, 63, 1, 6'b000000, 0, 0, 0);
        cyc("rst_hold1", 0, 1, 1, 63, 1, 6'b000000, 0, 0, 0);
        cyc("rst_rel",   1, 0, 0, 0,  0, 6'b000000, 0, 0, 0);

        // N=4 held; cycle count changes mid-op and must be ignored
        cyc("n4_c1", 1, 0, 1, 4, 0, 6'b001111, 0, 0, 0);
        cyc("n4_c2", 1, 0, 1, 1, 0, 6'b001111, 0, 1, 0);
        cyc("n4_c3", 1, 0, 1, 4, 0, 6'b001111, 0, 1, 0);
        cyc("n4_c4", 1, 0, 1, 4, 0, 6'b001111, 0, 1, 1);
        cyc("n4_c5", 1, 0, 0, 4, 0, 6'b000000, 0, 0, 0);

        // N=1 single cycle, then N=0 ignored in favour of the ID hold
        cyc("n1_c1",   1, 0, 1, 1, 0, 6'b001111, 0, 0, 1);
        cyc("n1_c2",   1, 0, 0, 1, 0, 6'b000000, 0, 0, 0);
        cyc("n0_id",   1, 1, 1, 0, 0, 6'b000111, 0, 0, 0);
        cyc("n0_none", 1, 0, 1, 0, 0, 6'b000000, 0, 0, 0);

        // Flush mid-op with N=10
        cyc("fl_c1", 1, 0, 1, 10, 0, 6'b001111, 0, 0, 0);
        cyc("fl_c2", 1, 0, 1, 10, 0, 6'b001111, 0, 1, 0);
        cyc("fl_c3", 1, 0, 1, 10, 1, 6'b000000, 1, 1, 0);
        cyc("fl_c4", 1, 0, 0, 10, 0, 6'b000000, 0, 0, 0);

        // Flush in IDLE wins over a start and over the ID hold
        cyc("fl_idle", 1, 1, 1, 5, 1, 6'b000000, 1, 0, 0);
        cyc("fl_after", 1, 0, 0, 5, 0, 6'b000000, 0, 0, 0);

        // Priority: EX hold over ID hold, then ID hold when the op ends
        cyc("pr_c1", 1, 1, 1, 3, 0, 6'b001111, 0, 0, 0);
        cyc("pr_c2", 1, 1, 1, 3, 0, 6'b001111, 0, 1, 0);
        cyc("pr_c3", 1, 1, 1, 3, 0, 6'b001111, 0, 1, 1);
        cyc("pr_c4", 1, 1, 0, 3, 0, 6'b000111, 0, 0, 0);
        cyc("pr_c5", 1, 0, 0, 3, 0, 6'b000000, 0, 0, 0);

        // Maximum count: exactly 63 stalled cycles
        for (int i = 1; i <= 63; i++) begin
            cyc($sformatf("n63_c%0d", i), 1, 0, 1, 63, 0, 6'b001111, 0,
                logic'(i > 1), logic'(i == 63));
        end
        cyc("n63_end", 1, 0, 0, 63, 0, 6'b000000, 0, 0, 0);

        // Async reset during BUSY (N=20), dropped between clock edges in cycle 5
        cyc("ar_c1", 1, 0, 1, 20, 0, 6'b001111, 0, 0, 0);
        cyc("ar_c2", 1, 0, 1, 20, 0, 6'b001111, 0, 1, 0);
        cyc("ar_c3", 1, 0, 1, 20, 0, 6'b001111, 0, 1, 0);
        cyc("ar_c4", 1, 0, 1, 20, 0, 6'b001111, 0, 1, 0);
        cyc("ar_c5", 0, 1, 1, 20, 0, 6'b000000, 0, 0, 0);
        cyc("ar_c6", 0, 1, 1, 20, 0, 6'b000000, 0, 0, 0);
        cyc("ar_rel", 1, 0, 0, 20, 0, 6'b000000, 0, 0, 0);
        cyc("ar_n2_c1", 1, 0, 1, 2, 0, 6'b001111, 0, 0, 0);
        cyc("ar_n2_c2", 1, 0, 1, 2, 0, 6'b001111, 0, 1, 1);
        cyc("ar_n2_c3", 1, 0, 0, 2, 0, 6'b000000, 0, 0, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        if (sb.size() > 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL provide parameter: MC_CNT_W, 6, width of the multi-cycle count input and of the internal down-counter.
REQ-002 SHALL provide port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL provide port: rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-004 SHALL provide port: id_stall_req  input  1  ID-stage hazard request; holds PC, IF/ID and ID/EX.
REQ-005 SHALL provide port: ex_mc_start  input  1  EX stage holds an op needing ex_mc_cycles total cycles.
REQ-006 SHALL provide port: ex_mc_cycles  input  MC_CNT_W  total EX cycles, N, for the op; sampled only when a start is accepted.
REQ-007 SHALL provide port: flush_req  input  1  pipeline flush request from the later stages.
REQ-008 SHALL provide port: stall  output  6  per-stage hold vector; bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
REQ-009 SHALL provide port: flush  output  1  clear IF/ID and ID/EX to their nop contents.
REQ-010 SHALL provide port: ex_mc_busy  output  1  high while the FSM is in BUSY.
REQ-011 SHALL provide port: ex_mc_done  output  1  high during the last stalled cycle of a multi-cycle op.

Function
REQ-012 SHALL implement a two-state FSM, IDLE and BUSY, with a MC_CNT_W-bit down-counter cnt.
REQ-013 Outputs SHALL be combinational from state, cnt and the current inputs, so a hold takes effect in the same cycle as the request.
REQ-014 Priority SHALL be flush_req > multi-cycle EX hold > id_stall_req.
REQ-015 flush_req=1 SHALL drive flush=1, stall=6'b000000, ex_mc_done=0, and SHALL force IDLE and cnt=0 at the next edge from either state.
REQ-016 In IDLE, a start SHALL be accepted when ex_mc_start=1, flush_req=0 and N>=1.
REQ-017 In IDLE, ex_mc_start=1 with N=0 SHALL be ignored: no hold, and id_stall_req rules apply.
REQ-018 When a start is accepted with N=1, the FSM SHALL drive stall=6'b001111 and ex_mc_done=1 for that cycle and SHALL remain in IDLE.
REQ-019 When a start is accepted with N>=2, the FSM SHALL drive stall=6'b001111 that cycle, move to BUSY, and load cnt<=N-1.
REQ-020 In BUSY without flush, the FSM SHALL drive stall=6'b001111 and ex_mc_busy=1, and SHALL decrement cnt each cycle.
REQ-021 In BUSY, cnt==1 SHALL drive ex_mc_done=1 and move the FSM to IDLE at the next edge.
REQ-022 Total stalled cycles per accepted op SHALL therefore equal N exactly (1..2^MC_CNT_W-1).
REQ-023 In BUSY, ex_mc_start and ex_mc_cycles SHALL be ignored, because the held EX stage keeps presenting them.
REQ-024 With no flush and no EX hold, id_stall_req=1 SHALL drive stall=6'b000111; otherwise stall=6'b000000.
REQ-025 flush SHALL be 0 whenever flush_req=0.
REQ-026 cnt SHALL never wrap: it is loaded only from IDLE with N>=2 and leaves BUSY at 1.

Reset
REQ-027 rst=0 SHALL asynchronously force IDLE and cnt=0.
REQ-028 While rst=0, the block SHALL drive stall=0, flush=0, ex_mc_busy=0 and ex_mc_done=0, regardless of the other inputs.
REQ-029 Reset asserted during BUSY SHALL abort the op; after release, the FSM SHALL accept a new start normally.

Structure
REQ-030 defines.v SHALL hold these constants: stall_bus width, the stall vectors stall_none/stall_id/stall_ex (6'b000000/6'b000111/6'b001111), the FSM encodings, and the reset-enable level for this block.
REQ-031 The counter (load, decrement, is-one flag) SHALL be one sub-module, mc_timer; the FSM and output logic SHALL stay in pipe_stall_ctrl.

Verification
REQ-032 Reset: hold rst=0 with all inputs high -> all outputs 0; release, inputs idle -> stall=0, ex_mc_busy=0.
REQ-033 Start N=4: ex_mc_start=1 held -> stall=6'b001111 for exactly 4 cycles; ex_mc_busy=1 in cycles 2-4; ex_mc_done=1 only in cycle 4; stall=0 in cycle 5.
REQ-034 Edge counts: N=1 -> a single-cycle hold with ex_mc_done=1 and ex_mc_busy never 1; N=0 plus id_stall_req=1 -> stall=6'b000111.
REQ-035 Flush mid-op: N=10, flush_req=1 in cycle 3 -> that cycle stall=0 and flush=1; next cycle IDLE with ex_mc_busy=0.
REQ-036 Priority: ex op in BUSY while id_stall_req=1 -> stall=6'b001111; after the op ends with id_stall_req=1 still high -> stall=6'b000111.
REQ-037 Async reset in BUSY (N=20, rst pulled low mid-cycle 5) -> outputs 0 immediately without a clock edge; a new start with N=2 after release -> 2 stalled cycles.
